ppm_symbol_decoder: RTL and testbench

Decodes 1-of-4 pulse-position-modulated symbols on `Din` into bytes once `sof_received` has flagged a start-of-frame. Sits directly downstream of `sof_received`, in the same `clk16` oversampled domain. Delivers each byte with a single-cycle valid strobe and flags end-of-frame or framing errors so the frame assembler can close or discard the frame.

---
 rtl/ppm_symbol_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ppm_symbol_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_symbol_decoder.sv
// ppm_symbol_decoder
//   Turns 1-of-4 pulse-position-modulated symbols on Din into bytes once a
//   start-of-frame pulse has been seen. Each symbol window is 4 slots of
//   SLOT_CYC clk16 cycles. Four symbols make one byte, and symbol 0 lands in
//   bits [1:0]. A silent window on a byte boundary ends the frame cleanly.
//   A silent window in the middle of a byte, or a window with more than one
//   pulse, aborts the frame.
//
//   Ports
//     clk16      in   oversampling clock, rising edge
//     rst_n      in   synchronous active-low reset
//     Din        in   line input, idle high, a low pulse marks the slot
//     sof_rcv    in   1-cycle start-of-frame pulse; RECV begins next cycle
//     data_out   out  last decoded byte, held until the next byte
//     data_valid out  1-cycle strobe, data_out is new
//     eof_rcv    out  1-cycle strobe, clean end of frame
//     frame_err  out  1-cycle strobe, frame aborted
//     busy       out  high while receiving
//
//   Build option
//     PPM_GLITCH_FILTER_EN: a pulse must stay low for two samples before it
//     counts, so single-cycle lows are ignored.
//
//   state | meaning
//   IDLE  | waiting for sof_rcv, counters held at zero
//   RECV  | timing symbol windows and collecting pulses
module ppm_symbol_decoder #(
  parameter int SLOT_CYC = 16
) (
  input  logic       clk16,
  input  logic       rst_n,
  input  logic       Din,
  input  logic       sof_rcv,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       eof_rcv,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYC - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic [1:0]    slot_cnt;
  logic [1:0]    sym_cnt;
  logic [1:0]    sym_val;
  logic [1:0]    pulse_cnt;
  logic [7:0]    byte_sr;
  logic          din_q;

  logic          slot_last;
  logic          win_end;
  logic          pulse_ev;
  logic [1:0]    ev_slot;
  logic [1:0]    pulse_nxt;
  logic [1:0]    sym_nxt;
  logic [7:0]    byte_nxt;

  assign slot_last = (cyc_cnt == CYC_LAST);
  assign win_end   = slot_last && (slot_cnt == 2'd3);

`ifdef PPM_GLITCH_FILTER_EN
  logic din_qq;
  logic win_first;
  logic confirm_ev;
  logic early_ev;

  // A pulse is confirmed on its second low sample, and its slot comes from
  // the first low sample (the previous cycle). A low that starts in the
  // final cycle of a window cannot be confirmed before that window is
  // decided, so it is accepted there. Its confirmation in the next window's
  // first cycle is then ignored so the pulse is not counted twice. The same
  // rule drops a low that was already present when RECV started.
  assign win_first  = (cyc_cnt == '0) && (slot_cnt == 2'd0);
  assign confirm_ev = din_qq && !din_q && !Din && !win_first;
  assign early_ev   = win_end && din_q && !Din;
  assign pulse_ev   = confirm_ev || early_ev;

  always_comb begin
    ev_slot = slot_cnt;
    if (confirm_ev && (cyc_cnt == '0)) ev_slot = slot_cnt - 2'd1;
  end
`else
  assign pulse_ev = din_q && !Din;
  assign ev_slot  = slot_cnt;
`endif

  // Window decisions include an event in the window's final cycle, so they
  // are made on the next-state values.
  always_comb begin
    pulse_nxt = pulse_cnt;
    if (pulse_ev && (pulse_cnt != 2'd2)) pulse_nxt = pulse_cnt + 2'd1;
  end

  assign sym_nxt  = pulse_ev ? ev_slot : sym_val;
  assign byte_nxt = {sym_nxt, byte_sr[7:2]};

  always_ff @(posedge clk16) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      slot_cnt   <= 2'd0;
      sym_cnt    <= 2'd0;
      sym_val    <= 2'd0;
      pulse_cnt  <= 2'd0;
      byte_sr    <= 8'h00;
      din_q      <= 1'b1;
`ifdef PPM_GLITCH_FILTER_EN
      din_qq     <= 1'b1;
`endif
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      eof_rcv    <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      din_q      <= Din;
`ifdef PPM_GLITCH_FILTER_EN
      din_qq     <= din_q;
`endif
      data_valid <= 1'b0;
      eof_rcv    <= 1'b0;
      frame_err  <= 1'b0;

      unique case (state)
        IDLE: begin
          busy      <= 1'b0;
          cyc_cnt   <= '0;
          slot_cnt  <= 2'd0;
          sym_cnt   <= 2'd0;
          sym_val   <= 2'd0;
          pulse_cnt <= 2'd0;
          if (sof_rcv) begin
            state   <= RECV;
            busy    <= 1'b1;
            byte_sr <= 8'h00;
          end
        end

        RECV: begin
          pulse_cnt <= pulse_nxt;
          sym_val   <= sym_nxt;
          if (slot_last) begin
            cyc_cnt  <= '0;
            slot_cnt <= slot_cnt + 2'd1;
          end else begin
            cyc_cnt  <= cyc_cnt + CW'(1);
          end

          if (win_end) begin
            pulse_cnt <= 2'd0;
            unique case (pulse_nxt)
              2'd1: begin
                byte_sr <= byte_nxt;
                if (sym_cnt == 2'd3) begin
                  data_out   <= byte_nxt;
                  data_valid <= 1'b1;
                  sym_cnt    <= 2'd0;
                end else begin
                  sym_cnt    <= sym_cnt + 2'd1;
                end
              end
              2'd0: begin
                if (sym_cnt == 2'd0) eof_rcv   <= 1'b1;
                else                 frame_err <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
              default: begin
                frame_err <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
              end
            endcase
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_symbol_decoder.sv
module tb_ppm_symbol_decoder;
  localparam int S = 4;
  localparam int W = 4 * S;

  logic       clk16 = 1'b0;
  logic       rst_n = 1'b0;
  logic       Din = 1'b1;
  logic       sof_rcv = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       eof_rcv;
  logic       frame_err;
  logic       busy;

  ppm_symbol_decoder #(.SLOT_CYC(S)) dut (
    .clk16(clk16), .rst_n(rst_n), .Din(Din), .sof_rcv(sof_rcv),
    .data_out(data_out), .data_valid(data_valid), .eof_rcv(eof_rcv),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk16 = ~clk16;

  int unsigned pcount = 0;
  always @(posedge clk16) pcount <= pcount + 1;

  // kind: 0 = byte, 1 = end of frame, 2 = frame error
  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  exp_t       expq[$];
  bit         wave[$];
  bit         sofm[$];
  bit         pre;
  logic [7:0] exp_data = 8'h00;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: looks at the whole Din waveform window by window,
  // counts falling edges, and predicts each strobe and the posedge count
  // at which it becomes visible.
  function automatic int model(input int unsigned c0);
    int   nsym;
    int   acc;
    int   cnt;
    int   val;
    bit   p;
    bit   c;
    exp_t e;
    nsym = 0;
    acc  = 0;
    for (int w = 0; (w + 1) * W <= wave.size(); w++) begin
      cnt = 0;
      val = 0;
      for (int o = 0; o < W; o++) begin
        c = wave[w*W+o];
        p = (w == 0 && o == 0) ? pre : wave[w*W+o-1];
        if (p && !c) begin
          cnt++;
          val = o / S;
        end
      end
      e.at = c0 + 1 + W * (w + 1);
      if (cnt == 1) begin
        acc += val << (2 * nsym);
        nsym++;
        if (nsym == 4) begin
          exp_data = acc[7:0];
          e.kind = 0; e.data = exp_data;
          expq.push_back(e);
          nsym = 0;
          acc = 0;
        end
      end else begin
        e.kind = (cnt == 0 && nsym == 0) ? 1 : 2;
        e.data = exp_data;
        expq.push_back(e);
        return w + 1;
      end
    end
    return -1;
  endfunction

  function automatic void add_window(input int slot, input int off, input int len);
    int lo;
    lo = slot * S + off;
    for (int o = 0; o < W; o++)
      wave.push_back((slot >= 0 && o >= lo && o < lo + len) ? 1'b0 : 1'b1);
  endfunction

  function automatic void add_double(input int a, input int b);
    for (int o = 0; o < W; o++)
      wave.push_back((o == a * S || o == b * S) ? 1'b0 : 1'b1);
  endfunction

  function automatic void add_sym(input int slot);
    int off;
    int len;
    off = int'($urandom_range(0, S - 2));
    len = (off == S - 2) ? 1 : int'($urandom_range(1, 2));
    add_window(slot, off, len);
  endfunction

  function automatic void add_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) add_sym(int'((b >> (2 * k)) & 8'd3));
  endfunction

  task automatic drive_frame();
    int unsigned c0;
    int          n;
    int          len;
    @(posedge clk16); #1;
    c0 = pcount;
    sof_rcv = 1'b1;
    Din = pre;
    n = model(c0);
    len = (n > 0) ? n * W : wave.size();
    for (int j = 0; j < len; j++) begin
      @(posedge clk16); #1;
      if (j == 0) chk("busy_after_sof", busy, 1);
      sof_rcv = (j < sofm.size()) ? sofm[j] : 1'b0;
      Din = wave[j];
    end
    @(posedge clk16); #1;
    Din = 1'b1;
    sof_rcv = 1'b0;
    chk("busy_after_frame", busy, 0);
    repeat (3) @(posedge clk16);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge clk16) begin
    int   kind_now;
    exp_t e;
    if (rst_n && (data_valid || eof_rcv || frame_err)) begin
      chk("strobe_onehot", int'(data_valid) + int'(eof_rcv) + int'(frame_err), 1);
      kind_now = data_valid ? 0 : (eof_rcv ? 1 : 2);
      if (expq.size() == 0) begin
        chk("unexpected_strobe_kind", kind_now, -1);
      end else begin
        e = expq.pop_front();
        chk("strobe_kind", kind_now, e.kind);
        chk("strobe_cycle", pcount, e.at);
        chk("data_out", data_out, e.data);
        if (kind_now != 0) chk("busy_at_end", busy, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int term;
    int ns;
    int a;
    int b;

    repeat (3) @(posedge clk16);
    #1;
    chk("reset_data_out", data_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_strobes", int'(data_valid) + int'(eof_rcv) + int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk16);

    // Slots 0,1,2,3 -> 8'hE4, then a silent window.
    pre = 1'b1; wave.delete(); sofm.delete();
    for (int s = 0; s < 4; s++) add_window(s, 0, 2);
    add_window(-1, 0, 0);
    drive_frame();

    // 8'hFF then 8'h00, then silence.
    wave.delete();
    for (int s = 0; s < 4; s++) add_window(3, 0, 2);
    for (int s = 0; s < 4; s++) add_window(0, 1, 2);
    add_window(-1, 0, 0);
    drive_frame();

    // Two pulses in slots 1 and 2 of one window.
    wave.delete();
    add_double(1, 2);
    drive_frame();

    // A full byte, then two symbols and a silent window.
    wave.delete();
    add_byte(8'h39);
    add_sym(1); add_sym(2);
    add_window(-1, 0, 0);
    drive_frame();

    // Single-cycle low in slot 0 plus a 2-cycle pulse in slot 2.
    wave.delete();
    for (int o = 0; o < W; o++)
      wave.push_back((o == 1 || o == 2 * S || o == 2 * S + 1) ? 1'b0 : 1'b1);
    drive_frame();

    // Din already low when the frame starts: only the later edge counts.
    pre = 1'b0; wave.delete();
    for (int o = 0; o < W; o++)
      wave.push_back((o < 2 || o == 2 * S) ? 1'b0 : 1'b1);
    add_sym(1); add_sym(3); add_sym(0);
    add_window(-1, 0, 0);
    drive_frame();
    pre = 1'b1;

    // Reset part-way into symbol 2 of a byte.
    wave.delete();
    add_byte(8'hC6);
    @(posedge clk16); #1;
    sof_rcv = 1'b1; Din = 1'b1;
    for (int j = 0; j < 2 * W + 2 * S; j++) begin
      @(posedge clk16); #1;
      sof_rcv = 1'b0;
      Din = wave[j];
    end
    rst_n = 1'b0; Din = 1'b1;
    @(posedge clk16); #1;
    chk("midreset_data_out", data_out, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_strobes", int'(data_valid) + int'(eof_rcv) + int'(frame_err), 0);
    rst_n = 1'b1;
    exp_data = 8'h00;
    repeat (2) @(posedge clk16);

    // New frame 8'h1B with extra sof_rcv pulses while receiving.
    wave.delete(); sofm.delete();
    add_byte(8'h1B);
    add_window(-1, 0, 0);
    for (int j = 0; j < wave.size(); j++) sofm.push_back(j == 5 || j == 20 || j == 40);
    drive_frame();
    sofm.delete();

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      wave.delete();
      pre = ($urandom_range(0, 7) != 0);
      nb = int'($urandom_range(0, 3));
      for (int k = 0; k < nb; k++) add_byte(8'($urandom_range(0, 255)));
      term = int'($urandom_range(0, 2));
      case (term)
        0: add_window(-1, 0, 0);
        1: begin
          ns = int'($urandom_range(1, 3));
          for (int k = 0; k < ns; k++) add_sym(int'($urandom_range(0, 3)));
          add_window(-1, 0, 0);
        end
        default: begin
          a = int'($urandom_range(0, 2));
          b = int'($urandom_range(a + 1, 3));
          add_double(a, b);
        end
      endcase
      drive_frame();
    end

    repeat (5) @(posedge clk16);
    chk("scoreboard_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
